// File: rtl/pipeline_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_sequencer
//   Pipeline-control sequencer for the 5-stage RISC-V core. Turns load-use
//   hazards, branch mispredicts and data-memory wait states into PC /
//   pipeline-register write enables, flushes and the PC redirect select.
//   It also keeps two saturating profiling counters.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   hz_load_use       load-use hazard (level) from the hazard detector
//   br_mispredict     EX-stage mispredict (level, already qualified valid)
//   dmem_req          MEM stage is performing a data-memory access
//   dmem_ready        data memory has completed the access
//   perf_clr          synchronous clear of both counters
//   pc_write, if_id_write, ex_mem_write, mem_wb_write   register write enables
//   if_id_flush       IF/ID loads a NOP
//   id_ex_flush       ID/EX loads zeroed control (bubble)
//   pc_redirect       PC mux selects the EX-resolved branch target
//   state             0=RUN 1=LOAD_STALL 2=FLUSH 3=MEM_WAIT (debug/observe)
//   stall_cycles      cycles with pc_write=0, saturating
//   flush_events      accepted mispredicts, saturating
//
// Handshake note: this block has no valid/ready pairs. dmem_req/dmem_ready
// form a level protocol: a wait exists while dmem_req=1 and dmem_ready=0, and
// dmem_ready stays high until the pipeline advances.
// -----------------------------------------------------------------------------
module pipeline_hazard_sequencer #(
    parameter int LOAD_BUBBLES = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hz_load_use,
    input  logic             br_mispredict,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             perf_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             pc_redirect,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } state_t;

    localparam logic [3:0] LB_RELOAD = 4'(LOAD_BUBBLES - 1);
    localparam logic [3:0] FL_RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t     r_state, w_next_state;
    state_t     r_ret_state, w_next_ret_state;
    logic [3:0] r_bub_cnt, w_next_bub_cnt;

    logic w_mem_wait;
    logic w_freeze;
    logic w_take_mis;
    logic w_take_stall;
    logic w_flush_out;

    assign w_mem_wait = dmem_req & ~dmem_ready;
    assign state      = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_ret_state <= ST_RUN;
            r_bub_cnt   <= 4'd0;
        end else begin
            r_state     <= w_next_state;
            r_ret_state <= w_next_ret_state;
            r_bub_cnt   <= w_next_bub_cnt;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_ret_state = r_ret_state;
        w_next_bub_cnt   = r_bub_cnt;
        w_freeze         = 1'b0;
        w_take_mis       = 1'b0;
        w_take_stall     = 1'b0;
        w_flush_out      = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_mem_wait) begin
                    w_freeze         = 1'b1;
                    w_next_ret_state = ST_RUN;
                    w_next_state     = ST_MEM_WAIT;
                end else if (br_mispredict) begin
                    w_take_mis = 1'b1;
                end else if (hz_load_use) begin
                    w_take_stall = 1'b1;
                    if (LOAD_BUBBLES > 1) begin
                        w_next_bub_cnt = LB_RELOAD;
                        w_next_state   = ST_LOAD_STALL;
                    end
                end
            end
            ST_LOAD_STALL: begin
                // hz_load_use is deliberately not looked at here; it is
                // re-evaluated once the sequence returns to RUN.
                if (w_mem_wait) begin
                    w_freeze         = 1'b1;
                    w_next_ret_state = ST_LOAD_STALL;
                    w_next_state     = ST_MEM_WAIT;
                end else if (br_mispredict) begin
                    w_take_mis = 1'b1;
                end else begin
                    w_take_stall   = 1'b1;
                    w_next_bub_cnt = r_bub_cnt - 4'd1;
                    if (r_bub_cnt == 4'd1) w_next_state = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (w_mem_wait) begin
                    w_freeze         = 1'b1;
                    w_next_ret_state = ST_FLUSH;
                    w_next_state     = ST_MEM_WAIT;
                end else begin
                    w_flush_out    = 1'b1;
                    w_next_bub_cnt = r_bub_cnt - 4'd1;
                    if (r_bub_cnt == 4'd1) w_next_state = ST_RUN;
                end
            end
            default: begin
                // MEM_WAIT: frozen even in the cycle dmem_ready rises, so the
                // shortest wait costs two cycles.
                w_freeze = 1'b1;
                if (dmem_ready) w_next_state = r_ret_state;
            end
        endcase

        // An accepted mispredict drops any remaining load bubbles.
        if (w_take_mis) begin
            if (FLUSH_CYCLES > 1) begin
                w_next_bub_cnt = FL_RELOAD;
                w_next_state   = ST_FLUSH;
            end else begin
                w_next_bub_cnt = 4'd0;
                w_next_state   = ST_RUN;
            end
        end
    end

    // Output decode: start from "pass" and apply the selected action.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        pc_redirect  = 1'b0;

        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
        end else if (w_freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
        end else if (w_take_mis) begin
            pc_redirect = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_take_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (w_flush_out) begin
            if_id_flush = 1'b1;
        end
    end

    // Saturating profiling counters; perf_clr beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_write && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (w_take_mis && (flush_events != '1))
                flush_events <= flush_events + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Two instances share one stimulus stream: A (LOAD_BUBBLES=3, FLUSH_CYCLES=2,
// 4-bit counters so saturation is reachable) and B (1, 1, 32-bit counters).
// The reference model tracks remaining load bubbles, remaining flush cycles
// and a "waiting on memory" flag; the return context is simply whatever
// bubble/flush work was left when the wait began.
module tb_pipeline_hazard_sequencer;

    logic clk = 1'b0;
    logic rst, hz_load_use, br_mispredict, dmem_req, dmem_ready, perf_clr;

    always #5 clk = ~clk;

    logic        a_pcw, a_ifw, a_iff, a_idf, a_exw, a_mww, a_red;
    logic [1:0]  a_state;
    logic [3:0]  a_stall, a_flush;
    logic        b_pcw, b_ifw, b_iff, b_idf, b_exw, b_mww, b_red;
    logic [1:0]  b_state;
    logic [31:0] b_stall, b_flush;

    pipeline_hazard_sequencer #(.LOAD_BUBBLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) u_a (
        .clk(clk), .rst(rst), .hz_load_use(hz_load_use), .br_mispredict(br_mispredict),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
        .pc_write(a_pcw), .if_id_write(a_ifw), .if_id_flush(a_iff), .id_ex_flush(a_idf),
        .ex_mem_write(a_exw), .mem_wb_write(a_mww), .pc_redirect(a_red),
        .state(a_state), .stall_cycles(a_stall), .flush_events(a_flush)
    );

    pipeline_hazard_sequencer #(.LOAD_BUBBLES(1), .FLUSH_CYCLES(1), .CNT_W(32)) u_b (
        .clk(clk), .rst(rst), .hz_load_use(hz_load_use), .br_mispredict(br_mispredict),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
        .pc_write(b_pcw), .if_id_write(b_ifw), .if_id_flush(b_iff), .id_ex_flush(b_idf),
        .ex_mem_write(b_exw), .mem_wb_write(b_mww), .pc_redirect(b_red),
        .state(b_state), .stall_cycles(b_stall), .flush_events(b_flush)
    );

    // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush,
    //                       ex_mem_write, mem_wb_write, pc_redirect}
    localparam logic [6:0] O_PASS   = 7'b1100110;
    localparam logic [6:0] O_FREEZE = 7'b0000000;
    localparam logic [6:0] O_RST    = 7'b0011000;
    localparam logic [6:0] O_STALL  = 7'b0001110;
    localparam logic [6:0] O_REDIR  = 7'b1111111;
    localparam logic [6:0] O_FLUSH  = 7'b1110110;

    int n_checks = 0;
    int n_errors = 0;
    string cur_test = "init";

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          lb_p[2] = '{3, 1};
    int          fc_p[2] = '{2, 1};
    longint      cmax[2] = '{64'd15, 64'hFFFF_FFFF};
    bit          m_wait[2];
    int          m_ld[2];
    int          m_fl[2];
    longint      m_sc[2];
    longint      m_fe[2];
    bit          m_valid = 1'b0;

    task automatic model_eval(input int k, output logic [6:0] eo, output logic [1:0] es);
        bit inc_f;
        inc_f = 1'b0;
        es = m_wait[k] ? 2'd3 : (m_fl[k] > 0) ? 2'd2 : (m_ld[k] > 0) ? 2'd1 : 2'd0;
        if (rst) begin
            eo = O_RST;
            m_wait[k] = 1'b0; m_ld[k] = 0; m_fl[k] = 0; m_sc[k] = 0; m_fe[k] = 0;
        end else begin
            if (m_wait[k]) begin
                eo = O_FREEZE;
                if (dmem_ready) m_wait[k] = 1'b0;
            end else if (dmem_req && !dmem_ready) begin
                eo = O_FREEZE;
                m_wait[k] = 1'b1;
            end else if (m_fl[k] > 0) begin
                eo = O_FLUSH;
                m_fl[k]--;
            end else if (br_mispredict) begin
                eo = O_REDIR;
                inc_f = 1'b1;
                m_fl[k] = fc_p[k] - 1;
                m_ld[k] = 0;
            end else if (m_ld[k] > 0) begin
                eo = O_STALL;
                m_ld[k]--;
            end else if (hz_load_use) begin
                eo = O_STALL;
                m_ld[k] = lb_p[k] - 1;
            end else begin
                eo = O_PASS;
            end
            if (perf_clr) begin
                m_sc[k] = 0; m_fe[k] = 0;
            end else begin
                if (!eo[6] && m_sc[k] < cmax[k]) m_sc[k]++;
                if (inc_f && m_fe[k] < cmax[k]) m_fe[k]++;
            end
        end
    endtask

    // Drive inputs just after a rising edge, check on the falling edge.
    task automatic step(input bit r, input bit h, input bit m, input bit q, input bit y, input bit c);
        logic [6:0] eo, go;
        logic [1:0] es, gs;
        longint     ps, pf;
        logic [63:0] gsc, gfe;
        rst = r; hz_load_use = h; br_mispredict = m; dmem_req = q; dmem_ready = y; perf_clr = c;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            ps = m_sc[k];
            pf = m_fe[k];
            model_eval(k, eo, es);
            if (k == 0) begin
                go = {a_pcw, a_ifw, a_iff, a_idf, a_exw, a_mww, a_red};
                gs = a_state; gsc = 64'(a_stall); gfe = 64'(a_flush);
            end else begin
                go = {b_pcw, b_ifw, b_iff, b_idf, b_exw, b_mww, b_red};
                gs = b_state; gsc = 64'(b_stall); gfe = 64'(b_flush);
            end
            if (m_valid) begin
                check({cur_test, (k == 0) ? ".A" : ".B", ".outs"}, 64'(go), 64'(eo));
                check({cur_test, (k == 0) ? ".A" : ".B", ".state"}, 64'(gs), 64'(es));
                check({cur_test, (k == 0) ? ".A" : ".B", ".stall_cnt"}, gsc, 64'(ps));
                check({cur_test, (k == 0) ? ".A" : ".B", ".flush_cnt"}, gfe, 64'(pf));
            end
        end
        if (r) m_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; hz_load_use = 0; br_mispredict = 0; dmem_req = 0; dmem_ready = 0; perf_clr = 0;
        for (int k = 0; k < 2; k++) begin
            m_wait[k] = 0; m_ld[k] = 0; m_fl[k] = 0; m_sc[k] = 0; m_fe[k] = 0;
        end
        #1;

        cur_test = "reset";
        do_reset();
        check("reset.A.state", 64'(a_state), 64'd0);
        check("reset.A.stall_cnt", 64'(a_stall), 64'd0);

        // Single-cycle load-use on the one-bubble instance.
        cur_test = "t1";
        step(0, 1, 0, 0, 0, 0);
        idle(3);
        check("t1.B.stall_total", 64'(b_stall), 64'd1);

        // Three-bubble load-use from one pulse.
        cur_test = "t2";
        do_reset();
        step(0, 1, 0, 0, 0, 0);
        idle(4);
        check("t2.A.stall_total", 64'(a_stall), 64'd3);

        // Mispredict beats a simultaneous load-use.
        cur_test = "t3";
        do_reset();
        step(0, 1, 1, 0, 0, 0);
        idle(3);
        check("t3.A.flush_total", 64'(a_flush), 64'd1);
        check("t3.A.stall_total", 64'(a_stall), 64'd0);

        // Memory wait landing on the second load bubble.
        cur_test = "t4";
        do_reset();
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        idle(4);
        check("t4.A.stall_total", 64'(a_stall), 64'd8);

        // Reset while waiting on memory.
        cur_test = "t5";
        do_reset();
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        check("t5.A.state_after_rst", 64'(a_state), 64'd0);
        check("t5.A.stall_after_rst", 64'(a_stall), 64'd0);
        idle(3);

        // Counter saturation and clear-over-increment.
        cur_test = "t6";
        do_reset();
        for (int i = 0; i < 40; i++) step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 1, 0, 0, 0, 0);
        check("t6.A.stall_sat", 64'(a_stall), 64'd15);
        check("t6.A.flush_sat", 64'(a_flush), 64'd15);
        step(0, 1, 0, 0, 0, 1);
        check("t6.A.stall_clr", 64'(a_stall), 64'd0);
        check("t6.A.flush_clr", 64'(a_flush), 64'd0);
        idle(4);

        // Randomized traffic.
        cur_test = "rand";
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 1,
                 $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 12,
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 2);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
